// File: rtl/range_alert_if.sv
// Ranger-to-alert bus: measurement strobe in, filtered distance, zone and motor drive out.
// The master side is the ranging stage; the slave side is range_alert.
interface range_alert_if;
    logic        meas_valid;
    logic [15:0] meas_us;
    logic        meas_timeout;
    logic [8:0]  dist_cm;
    logic        dist_valid;
    logic [1:0]  zone;
    logic        motor_en;
    logic        fault;

    modport master (
        output meas_valid, meas_us, meas_timeout,
        input  dist_cm, dist_valid, zone, motor_en, fault
    );

    modport slave (
        input  meas_valid, meas_us, meas_timeout,
        output dist_cm, dist_valid, zone, motor_en, fault
    );
endinterface

// File: rtl/range_alert.sv
// Echo width -> cm conversion, median-of-3 filter, hysteretic proximity zones,
// glitch-free vibration PWM and a stale-measurement watchdog.
module range_alert #(
    parameter int NEAR_CM      = 50,
    parameter int FAR_CM       = 150,
    parameter int HYST_CM      = 5,
    parameter int MAX_CM       = 400,
    parameter int DUTY_NEAR    = 224,
    parameter int DUTY_FAR     = 64,
    parameter int STALE_CYCLES = 2500000
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    range_alert_if.slave bus
);

    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam logic [8:0]    NEAR_LO    = 9'(NEAR_CM);
    localparam logic [8:0]    FAR_LO     = 9'(FAR_CM);
    localparam logic [8:0]    NEAR_HI    = 9'(NEAR_CM + HYST_CM);
    localparam logic [8:0]    FAR_HI     = 9'(FAR_CM + HYST_CM);
    localparam logic [SW-1:0] STALE_LAST = SW'(STALE_CYCLES - 1);
    localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_CYCLES);

    typedef enum logic [1:0] {
        Z_CLEAR = 2'd0,
        Z_FAR   = 2'd1,
        Z_NEAR  = 2'd2,
        Z_STALE = 2'd3
    } zone_t;

    function automatic logic [8:0] med3(input logic [8:0] a, input logic [8:0] b,
                                        input logic [8:0] c);
        logic [8:0] lo, hi, hc;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        hc = (hi < c) ? hi : c;
        return (lo > hc) ? lo : hc;
    endfunction

    logic [15:0]   cm_raw;
    logic [8:0]    cm_in;
    logic          conv_vld;
    logic [8:0]    conv_cm;
    logic [8:0]    s0, s1;
    logic [1:0]    fill;
    logic [8:0]    dist_cm_q;
    logic          dist_vld;
    logic [SW-1:0] stale_cnt;
    logic          stale_hit;
    zone_t         zone_q, zone_d;
    logic [7:0]    zone_duty;
    logic [7:0]    pwm_cnt;
    logic [7:0]    active_duty;
    logic          motor_q;

    // 1130/65536 ~= 1/58 us-per-cm; the full 32-bit product keeps every input exact
    always_comb begin
        cm_raw = 16'(({16'd0, bus.meas_us} * 32'd1130) >> 16);
        cm_in  = cm_raw[8:0];
        if (bus.meas_timeout || cm_raw > 16'(MAX_CM))
            cm_in = 9'(MAX_CM);
    end

    assign stale_hit = !bus.meas_valid && (stale_cnt == STALE_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            conv_vld  <= 1'b0;
            conv_cm   <= '0;
            s0        <= '0;
            s1        <= '0;
            fill      <= '0;
            dist_cm_q <= '0;
            dist_vld  <= 1'b0;
            stale_cnt <= '0;
        end else begin
            conv_vld <= bus.meas_valid;
            if (bus.meas_valid)
                conv_cm <= cm_in;

            // s0/s1 plus the arriving sample form the three-entry window
            if (conv_vld) begin
                s0 <= conv_cm;
                s1 <= s0;
            end
            if (stale_hit)
                fill <= '0;
            else if (conv_vld && fill != 2'd3)
                fill <= fill + 2'd1;

            dist_vld <= conv_vld && (fill >= 2'd2);
            if (conv_vld && fill >= 2'd2)
                dist_cm_q <= med3(conv_cm, s0, s1);

            if (bus.meas_valid)
                stale_cnt <= '0;
            else if (stale_cnt != STALE_MAX)
                stale_cnt <= stale_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) zone_q <= Z_CLEAR;
        else         zone_q <= zone_d;
    end

    // STALE re-enters through the CLEAR row once the refilled window yields a distance
    always_comb begin
        zone_d = zone_q;
        if (stale_hit)
            zone_d = Z_STALE;
        else if (dist_vld) begin
            case (zone_q)
                Z_FAR: begin
                    if (dist_cm_q < NEAR_LO)      zone_d = Z_NEAR;
                    else if (dist_cm_q >= FAR_HI) zone_d = Z_CLEAR;
                end
                Z_NEAR: begin
                    if (dist_cm_q >= FAR_HI)       zone_d = Z_CLEAR;
                    else if (dist_cm_q >= NEAR_HI) zone_d = Z_FAR;
                end
                default: begin
                    if (dist_cm_q < NEAR_LO)     zone_d = Z_NEAR;
                    else if (dist_cm_q < FAR_LO) zone_d = Z_FAR;
                    else                         zone_d = Z_CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        zone_duty = 8'd0;
        case (zone_q)
            Z_NEAR:  zone_duty = 8'(DUTY_NEAR);
            Z_FAR:   zone_duty = 8'(DUTY_FAR);
            default: zone_duty = 8'd0;
        endcase
    end

    // Duty only changes at the period boundary so pulses are never clipped,
    // except a stale fault which kills the motor straight away.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pwm_cnt     <= '0;
            active_duty <= '0;
            motor_q     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (stale_hit)
                active_duty <= '0;
            else if (pwm_cnt == 8'hFF)
                active_duty <= zone_duty;
            motor_q <= (pwm_cnt < active_duty);
        end
    end

    assign bus.dist_cm    = dist_cm_q;
    assign bus.dist_valid = dist_vld;
    assign bus.zone       = zone_q;
    assign bus.motor_en   = motor_q;
    assign bus.fault      = (zone_q == Z_STALE);

endmodule
